sparse_reduce_tree: RTL
=======================

# sparse_reduce_tree

Parametrised, fully pipelined reduction tree with valid tracking, per-lane sparsity masking, signed/unsigned operands and an optional saturating group accumulator. It sits after the PE multiplier array in the sparse tensor core and reduces NUM_IN partial products per beat into one dot-product term. In accumulate mode it sums successive beats over a K-dimension group delimited by in_last. It replaces the fixed 8-input, 3-level, unmasked tree.

## Interface
- NUM_IN, 8, number of input lanes; power of two, ≥2
- DW_IN, 8, width of each input lane
- DW_ACC, 24, output/accumulator width; must be ≥ DW_IN+log2(NUM_IN)
- SIGNED, 1, 1 = two's-complement operands and result, 0 = unsigned
- ACC_EN, 1, 1 = accumulate beats until in_last, 0 = one output per beat
- LEVELS (localparam), log2(NUM_IN), tree depth

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  beat valid
- in_data  in  NUM_IN*DW_IN  lane i at [i*DW_IN +: DW_IN]
- in_mask  in  NUM_IN  1 = lane contributes, 0 = lane treated as zero
- in_last  in  1  last beat of group; ignored when ACC_EN=0
- out_valid  out  1  result valid, single-cycle pulse per result
- out_sum  out  DW_ACC  result, sign- or zero-extended per SIGNED
- out_ovf  out  1  saturation occurred in the group; qualified by out_valid

## Operation
- Lane data is ANDed with its mask bit, then extended to DW_IN+1 (sign-extended if SIGNED, else zero-extended).
- Level k (1..LEVELS) adds pairs from level k-1 into registers of width DW_IN+k. The tree is exact and never overflows.
- A valid bit and a last bit travel with each level. Level data registers load only when the incoming valid is 1.
- Tree output is extended to DW_ACC.
- ACC_EN=0: each tree-valid beat loads out_sum with the tree sum and pulses out_valid. out_ovf=0.
- ACC_EN=1, accumulator register acc (DW_ACC) plus sticky ovf flag:
  - The new sum is acc + tree sum, saturated to the DW_ACC signed range [-2^(DW_ACC-1), 2^(DW_ACC-1)-1], or to [0, 2^DW_ACC-1] if unsigned. Saturation sets ovf.
  - Non-last beat: acc and ovf take the new values. out_valid=0 and out_sum holds.
  - Last beat: out_sum takes the new sum, out_ovf takes (ovf OR this beat saturated), out_valid pulses. acc and ovf clear to 0, so the next beat starts a fresh group.
- Masked-out-everything beat (mask=0) is still a beat: it contributes 0 and honours in_last.
- in_valid low (bubble) changes no data or accumulator state. Groups may span arbitrary bubbles.

## Timing
- Throughput: one beat per clock, no backpressure.
- Latency: LEVELS+1 cycles from the in_valid (or in_last) beat to out_valid. For NUM_IN=8 this is 4 cycles.
- Reset: all level valid bits, acc, ovf, out_valid, out_sum and out_ovf go to 0 on the clock where rst=1.
  - Beats in flight and a partial group are dropped; no out_valid results from them.
  - Reset takes priority over a simultaneous in_valid.
- out_valid is high for exactly one cycle per result. Back-to-back results give consecutive pulses.
- Single-beat group (in_last on a fresh group) outputs that beat's sum.

## Test plan
All cases use NUM_IN=8, DW_IN=8.
- ACC_EN=0, SIGNED=1: lanes 1..8, mask 0xFF, one valid beat -> out_valid exactly 4 cycles later with out_sum=36 and out_ovf=0; out_valid low otherwise.
- ACC_EN=0, SIGNED=1: all lanes 0x80 (-128) with mask 0xFF -> out_sum=-1024. Next beat: all lanes 10 with mask 0x0F -> out_sum=40 on the following cycle. Then SIGNED=0 with all lanes 0xFF -> out_sum=2040.
- ACC_EN=1: three beats of all-ones, in_last on the third, sent back-to-back -> a single out_valid 4 cycles after the third beat with out_sum=24. Repeating with 2-cycle bubbles between beats gives the same result.
- ACC_EN=1, DW_ACC=12, SIGNED=1: three beats of all 127 (1016 each), in_last on the third -> out_sum=2047 with out_ovf=1. Next group: one beat of all 1s with in_last -> out_sum=8 with out_ovf=0.
- Reset mid-operation: two non-last beats of all 3s, then rst for 1 cycle, then one beat of all 5s with in_last -> only one out_valid, with out_sum=40. All outputs are 0 during the cycle after rst.
- Stream check: 1000 random beats with random masks and random in_last at full rate, for both ACC_EN values -> every out_sum, out_ovf and out_valid position matches the reference model.

Source files
------------

// File: rtl/sparse_reduce_tree.sv
// sparse_reduce_tree: pipelined, masked adder tree reducing NUM_IN lanes per
// beat into one dot-product term, with an optional saturating accumulator that
// sums beats over a group closed by in_last.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   in_valid            beat valid
//   in_data             NUM_IN lanes, lane i at [i*DW_IN +: DW_IN]
//   in_mask             per-lane enable (0 = lane contributes zero)
//   in_last             closes an accumulation group (ignored if ACC_EN=0)
//   out_valid           one-cycle pulse per result
//   out_sum             result, DW_ACC wide, sign/zero-extended per SIGNED
//   out_ovf             group saturated; qualified by out_valid
//
// Latency is LEVELS+1 cycles: LEVELS adder stages plus the output register.

// Per-lane sparsity gate.
module sparse_reduce_lane #(
  parameter int DW_IN = 8
) (
  input  logic [DW_IN-1:0] data,
  input  logic             mask,
  output logic [DW_IN-1:0] masked
);
  assign masked = data & {DW_IN{mask}};
endmodule

module sparse_reduce_tree #(
  parameter int NUM_IN = 8,
  parameter int DW_IN  = 8,
  parameter int DW_ACC = 24,
  parameter int SIGNED = 1,
  parameter int ACC_EN = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [NUM_IN*DW_IN-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_mask,
  input  logic                    in_last,
  output logic                    out_valid,
  output logic [DW_ACC-1:0]       out_sum,
  output logic                    out_ovf
);
  localparam int   LEVELS = $clog2(NUM_IN);
  localparam int   TW     = DW_IN + LEVELS;
  localparam logic SX     = (SIGNED != 0);

  // Stage 0 is the raw input beat; stages 1..LEVELS are registered.
  logic [LEVELS:1] vld_r, lst_r;
  logic [LEVELS:0] vld_pipe, lst_pipe;
  assign vld_pipe = {vld_r, in_valid};
  assign lst_pipe = {lst_r, in_last};

  logic [NUM_IN-1:0][DW_IN-1:0] lane_q;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_lane
    sparse_reduce_lane #(.DW_IN(DW_IN)) u_lane (
      .data  (in_data[i*DW_IN +: DW_IN]),
      .mask  (in_mask[i]),
      .masked(lane_q[i])
    );
  end

  // Level k holds NUM_IN>>k partial sums of DW_IN+k bits. Each adder widens
  // its operands by one bit (sign or zero), so level 0 can stay at DW_IN and
  // the tree stays exact at every level.
  for (genvar k = 0; k <= LEVELS; k++) begin : lvl
    localparam int N = NUM_IN >> k;
    localparam int W = DW_IN + k;
    logic [N-1:0][W-1:0] d;

    if (k == 0) begin : g_in
      assign d = lane_q;
    end else begin : g_add
      logic [N-1:0][W-1:0] s;
      always_comb begin
        for (int i = 0; i < N; i++)
          s[i] = {SX & lvl[k-1].d[2*i][W-2],   lvl[k-1].d[2*i]}
               + {SX & lvl[k-1].d[2*i+1][W-2], lvl[k-1].d[2*i+1]};
      end
      // Data only moves with a valid beat, so bubbles leave it untouched.
      always_ff @(posedge clk)
        if (vld_pipe[k-1]) d <= s;
    end
  end

  logic [TW-1:0]     tree_sum;
  logic [DW_ACC-1:0] tree_ext;
  assign tree_sum = lvl[LEVELS].d[0];
  assign tree_ext = SX ? DW_ACC'($signed(tree_sum)) : DW_ACC'(tree_sum);

  // Saturating accumulate, computed one bit wider to expose the carry/sign.
  logic [DW_ACC-1:0] acc, new_sum;
  logic [DW_ACC:0]   raw;
  logic              ovf, sat;

  always_comb begin
    raw     = {SX & acc[DW_ACC-1], acc} + {SX & tree_ext[DW_ACC-1], tree_ext};
    new_sum = raw[DW_ACC-1:0];
    sat     = 1'b0;
    if (SX) begin
      // Signed overflow: the extra bit disagrees with the result sign.
      if (raw[DW_ACC] != raw[DW_ACC-1]) begin
        sat     = 1'b1;
        new_sum = raw[DW_ACC] ? {1'b1, {(DW_ACC-1){1'b0}}}
                              : {1'b0, {(DW_ACC-1){1'b1}}};
      end
    end else if (raw[DW_ACC]) begin
      sat     = 1'b1;
      new_sum = '1;
    end
  end

  // The last flag rides with its beat and only updates on valid stages.
  always_ff @(posedge clk) begin
    for (int k = 1; k <= LEVELS; k++)
      if (vld_pipe[k-1]) lst_r[k] <= lst_pipe[k-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_r     <= '0;
      acc       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
    end else begin
      vld_r     <= vld_pipe[LEVELS-1:0];
      out_valid <= 1'b0;
      if (vld_pipe[LEVELS]) begin
        if (ACC_EN == 0) begin
          out_valid <= 1'b1;
          out_sum   <= tree_ext;
          out_ovf   <= 1'b0;
        end else if (lst_pipe[LEVELS]) begin
          // Close the group and start the next one from zero.
          out_valid <= 1'b1;
          out_sum   <= new_sum;
          out_ovf   <= ovf | sat;
          acc       <= '0;
          ovf       <= 1'b0;
        end else begin
          acc <= new_sum;
          ovf <= ovf | sat;
        end
      end
    end
  end
endmodule
